// File: rtl/regfl_mp.sv
// regfl_mp: parametrised register file with one write port and two registered read ports.
// Each read port has write-to-read bypass and returns a per-entry valid flag. A clear-all
// sweep zeroes one entry per cycle while busy is high.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   wr_e/wr_addr/wr_data  write port (dropped when out of range, during a sweep, or with clr_req)
//   rd_addr0/1            read addresses, sampled every edge
//   rd_data0/1, rd_vld0/1 registered read data and entry-valid flags
//   clr_req               starts a clear sweep from idle
//   busy                  high while the sweep is running
module regfl_mp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_e,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  output logic             rd_vld0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  output logic             rd_vld1,
  input  logic             clr_req,
  output logic             busy
);

  // Extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [WIDTH-1:0] rd_data0_q, rd_data0_d;
  logic [WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic             rd_vld0_q, rd_vld0_d;
  logic             rd_vld1_q, rd_vld1_d;

  logic wr_in_range, rd0_in_range, rd1_in_range;
  logic wr_ok;
  logic clearing;

  assign wr_in_range  = {1'b0, wr_addr} < DepthW;
  assign rd0_in_range = {1'b0, rd_addr0} < DepthW;
  assign rd1_in_range = {1'b0, rd_addr1} < DepthW;

  assign clearing = (state_q == StClear);
  // clr_req wins over a simultaneous write.
  assign wr_ok    = (state_q == StIdle) && wr_e && !clr_req && wr_in_range;

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        if (clr_cnt_q == LastIdx) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Read port 0: bypass beats the array; out-of-range reads return zero/invalid.
  always_comb begin
    rd_data0_d = '0;
    rd_vld0_d  = 1'b0;
    if (wr_ok && (wr_addr == rd_addr0)) begin
      rd_data0_d = wr_data;
      rd_vld0_d  = 1'b1;
    end else if (rd0_in_range) begin
      rd_data0_d = mem_q[rd_addr0];
      rd_vld0_d  = valid_q[rd_addr0];
    end
  end

  // Read port 1: same behaviour as port 0.
  always_comb begin
    rd_data1_d = '0;
    rd_vld1_d  = 1'b0;
    if (wr_ok && (wr_addr == rd_addr1)) begin
      rd_data1_d = wr_data;
      rd_vld1_d  = 1'b1;
    end else if (rd1_in_range) begin
      rd_data1_d = mem_q[rd_addr1];
      rd_vld1_d  = valid_q[rd_addr1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      valid_q    <= '0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      rd_vld0_q  <= 1'b0;
      rd_vld1_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      rd_vld0_q  <= rd_vld0_d;
      rd_vld1_q  <= rd_vld1_d;
      // Writes only happen in idle and clears only in the sweep, so these never collide.
      if (wr_ok) begin
        mem_q[wr_addr]   <= wr_data;
        valid_q[wr_addr] <= 1'b1;
      end
      if (clearing) begin
        mem_q[clr_cnt_q]   <= '0;
        valid_q[clr_cnt_q] <= 1'b0;
      end
    end
  end

  assign rd_data0 = rd_data0_q;
  assign rd_data1 = rd_data1_q;
  assign rd_vld0  = rd_vld0_q;
  assign rd_vld1  = rd_vld1_q;
  assign busy     = clearing;

endmodule

// File: tb/tb_regfl_mp.sv
// Self-checking bench for regfl_mp: a 4-entry and a 5-entry instance share one clock.
// Each stimulus row carries the outputs expected after its edge; the drive task pushes
// that expectation into a scoreboard queue and the test task pops and compares it.
module tb_regfl_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Expected/observed output vector: {rd_data0, rd_vld0, rd_data1, rd_vld1, busy}.
  typedef struct packed {
    logic        r;
    logic        clr;
    logic        we;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic [2:0]  a0;
    logic [2:0]  a1;
    logic [18:0] exp;
  } row_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [18:0] q4[$];
  logic [18:0] q5[$];

  // 4-entry instance
  logic       rst4 = 1'b0, wr_e4 = 1'b0, clr4 = 1'b0;
  logic [1:0] wa4 = '0, ra0_4 = '0, ra1_4 = '0;
  logic [7:0] wd4 = '0, rd0_4, rd1_4;
  logic       rv0_4, rv1_4, busy4;

  regfl_mp #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk      (clk),
    .rst      (rst4),
    .wr_e     (wr_e4),
    .wr_addr  (wa4),
    .wr_data  (wd4),
    .rd_addr0 (ra0_4),
    .rd_data0 (rd0_4),
    .rd_vld0  (rv0_4),
    .rd_addr1 (ra1_4),
    .rd_data1 (rd1_4),
    .rd_vld1  (rv1_4),
    .clr_req  (clr4),
    .busy     (busy4)
  );

  // 5-entry instance
  logic       rst5 = 1'b0, wr_e5 = 1'b0, clr5 = 1'b0;
  logic [2:0] wa5 = '0, ra0_5 = '0, ra1_5 = '0;
  logic [7:0] wd5 = '0, rd0_5, rd1_5;
  logic       rv0_5, rv1_5, busy5;

  regfl_mp #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk      (clk),
    .rst      (rst5),
    .wr_e     (wr_e5),
    .wr_addr  (wa5),
    .wr_data  (wd5),
    .rd_addr0 (ra0_5),
    .rd_data0 (rd0_5),
    .rd_vld0  (rv0_5),
    .rd_addr1 (ra1_5),
    .rd_data1 (rd1_5),
    .rd_vld1  (rv1_5),
    .clr_req  (clr5),
    .busy     (busy5)
  );

  wire [18:0] obs4 = {rd0_4, rv0_4, rd1_4, rv1_4, busy4};
  wire [18:0] obs5 = {rd0_5, rv0_5, rd1_5, rv1_5, busy5};

  function automatic row_t mk(input logic r, input logic clr, input logic we,
                              input logic [2:0] wa, input logic [7:0] wd,
                              input logic [2:0] a0, input logic [2:0] a1,
                              input logic [7:0] d0, input logic v0,
                              input logic [7:0] d1, input logic v1, input logic b);
    row_t x;
    x.r = r; x.clr = clr; x.we = we; x.wa = wa; x.wd = wd; x.a0 = a0; x.a1 = a1;
    x.exp = {d0, v0, d1, v1, b};
    return x;
  endfunction

  task automatic step4(input row_t x);
    rst4 = x.r; clr4 = x.clr; wr_e4 = x.we; wa4 = x.wa[1:0]; wd4 = x.wd;
    ra0_4 = x.a0[1:0]; ra1_4 = x.a1[1:0];
    q4.push_back(x.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic step5(input row_t x);
    rst5 = x.r; clr5 = x.clr; wr_e5 = x.we; wa5 = x.wa; wd5 = x.wd;
    ra0_5 = x.a0; ra1_5 = x.a1;
    q5.push_back(x.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [18:0] e;
    rows.push_back(mk(1, 0, 0, 0, 8'h00, 0, 3, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 8'h00, 0, 3, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 0, 3, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 3, 0, 8'h00, 0, 8'h00, 0, 0));
    foreach (rows[i]) begin
      step4(rows[i]);
      e = q4.pop_front();
      n_checks++;
      if (obs4 !== e) begin
        n_errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs4, e);
      end
    end
  endtask

  task automatic test_write_read();
    row_t rows[$];
    logic [18:0] e;
    rows.push_back(mk(0, 0, 1, 1, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 1, 2, 8'h3C, 1, 0, 8'hA5, 1, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 1, 2, 8'hA5, 1, 8'h3C, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    foreach (rows[i]) begin
      step4(rows[i]);
      e = q4.pop_front();
      n_checks++;
      if (obs4 !== e) begin
        n_errors++;
        $display("FAIL write_read[%0d]: got %h want %h", i, obs4, e);
      end
    end
  endtask

  task automatic test_bypass();
    row_t rows[$];
    logic [18:0] e;
    rows.push_back(mk(0, 0, 1, 3, 8'h77, 3, 3, 8'h77, 1, 8'h77, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 3, 1, 8'h77, 1, 8'hA5, 1, 0));
    foreach (rows[i]) begin
      step4(rows[i]);
      e = q4.pop_front();
      n_checks++;
      if (obs4 !== e) begin
        n_errors++;
        $display("FAIL bypass[%0d]: got %h want %h", i, obs4, e);
      end
    end
  endtask

  task automatic test_clear();
    row_t rows[$];
    logic [18:0] e;
    // Fill entry 0 so all four are valid: {11, A5, 3C, 77}.
    rows.push_back(mk(0, 0, 1, 0, 8'h11, 0, 1, 8'h11, 1, 8'hA5, 1, 0));
    // clr_req with a write to 0: write dropped, busy rises.
    rows.push_back(mk(0, 1, 1, 0, 8'hFF, 0, 3, 8'h11, 1, 8'h77, 1, 1));
    // Writes during the sweep are ignored; entries read old values on the edge they clear.
    rows.push_back(mk(0, 0, 1, 1, 8'hEE, 0, 1, 8'h11, 1, 8'hA5, 1, 1));
    rows.push_back(mk(0, 1, 1, 2, 8'hEE, 0, 2, 8'h00, 0, 8'h3C, 1, 1));
    rows.push_back(mk(0, 0, 1, 3, 8'hEE, 1, 3, 8'h00, 0, 8'h77, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 1, 3, 8'h00, 0, 8'h77, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 2, 3, 8'h00, 0, 8'h00, 0, 0));
    // First cycle after busy falls: write accepted (seen via bypass on port 1).
    rows.push_back(mk(0, 0, 1, 1, 8'h5A, 0, 1, 8'h00, 0, 8'h5A, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 1, 8'h00, 0, 0));
    foreach (rows[i]) begin
      step4(rows[i]);
      e = q4.pop_front();
      n_checks++;
      if (obs4 !== e) begin
        n_errors++;
        $display("FAIL clear[%0d]: got %h want %h", i, obs4, e);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    row_t rows[$];
    logic [18:0] e;
    rows.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1, 8'h5A, 1, 8'h5A, 1, 1));
    rows.push_back(mk(1, 0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 8'h12, 1, 2, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 0, 3, 8'h12, 1, 8'h00, 0, 0));
    foreach (rows[i]) begin
      step4(rows[i]);
      e = q4.pop_front();
      n_checks++;
      if (obs4 !== e) begin
        n_errors++;
        $display("FAIL reset_mid_clear[%0d]: got %h want %h", i, obs4, e);
      end
    end
  endtask

  task automatic test_non_pow2();
    row_t rows[$];
    logic [18:0] e;
    rows.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 1, 6, 8'h66, 6, 7, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 6, 7, 8'h00, 0, 8'h00, 0, 0));
    rows.push_back(mk(0, 0, 1, 4, 8'h44, 7, 4, 8'h00, 0, 8'h44, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 4, 7, 8'h44, 1, 8'h00, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 8'h00, 4, 0, 8'h44, 1, 8'h00, 0, 1));
    // Entry 4 is cleared on the fifth sweep edge, so it reads 44 until then.
    for (int k = 1; k <= 5; k++) begin
      rows.push_back(mk(0, 0, 0, 0, 8'h00, 4, 4, 8'h44, 1, 8'h44, 1, (k < 5)));
    end
    rows.push_back(mk(0, 0, 0, 0, 8'h00, 4, 0, 8'h00, 0, 8'h00, 0, 0));
    foreach (rows[i]) begin
      step5(rows[i]);
      e = q5.pop_front();
      n_checks++;
      if (obs5 !== e) begin
        n_errors++;
        $display("FAIL non_pow2[%0d]: got %h want %h", i, obs5, e);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_non_pow2();
    n_checks++;
    if ((q4.size() + q5.size()) != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", q4.size() + q5.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
